// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - load/run/drain sequencer for the radix-2 FFT stage pipeline
// Optional stage watchdog: define FFT_SEQ_WDOG_EN to enable it; otherwise err is tied 0.
module fft_stage_sequencer #(
  parameter int NUMSTAGES   = 5,
  parameter int WDOG_CYCLES = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       load_done,
  input  logic       stage_done_tgl,
  input  logic       out_ready,
  output logic       load_req,
  output logic       stage_en,
  output logic [2:0] stage_num,
  output logic       buf_sel,
  output logic       busy,
  output logic       out_valid,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_GAP,
    S_DRAIN
  } state_t;

  localparam logic [2:0] LAST_STAGE = 3'(NUMSTAGES - 1);

  state_t     r_state;
  logic       r_tgl_q;
  logic       r_load_req;
  logic       r_stage_en;
  logic [2:0] r_stage_num;
  logic       r_buf_sel;
  logic       r_busy;
  logic       r_out_valid;
  logic       r_done;

  logic       w_edge;
  logic       w_last_stage;
  logic       w_wdog_fire;

  // Any level change of the toggle since last cycle marks one finished stage.
  assign w_edge       = stage_done_tgl ^ r_tgl_q;
  assign w_last_stage = (r_stage_num == LAST_STAGE);

`ifdef FFT_SEQ_WDOG_EN
  logic [4:0] r_wdog;
  logic       r_err;

  // The watchdog trips on the RUN cycle that would be the WDOG_CYCLES-th without an edge.
  assign w_wdog_fire = (r_state == S_RUN) && !w_edge && (r_wdog == 5'(WDOG_CYCLES - 1));

  // Count edge-less RUN cycles; any other state (including RUN entry) restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= 5'd0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_RUN && !w_edge && !w_wdog_fire) begin
        r_wdog <= r_wdog + 5'd1;
      end else begin
        r_wdog <= 5'd0;
      end
      if (w_wdog_fire) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_wdog_fire = 1'b0;
  assign err         = 1'b0;
`endif

  // Lifecycle FSM: IDLE -> LOAD -> (RUN -> GAP)* -> RUN -> DRAIN -> IDLE, with abort back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tgl_q     <= 1'b0;
      r_load_req  <= 1'b0;
      r_stage_en  <= 1'b0;
      r_stage_num <= 3'd0;
      r_buf_sel   <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_tgl_q <= stage_done_tgl;
      r_done  <= 1'b0;
      if (r_state != S_IDLE && (abort || w_wdog_fire)) begin
        // Cancel: drop every request and forget the partial transform, no done pulse.
        r_state     <= S_IDLE;
        r_load_req  <= 1'b0;
        r_stage_en  <= 1'b0;
        r_stage_num <= 3'd0;
        r_buf_sel   <= 1'b0;
        r_busy      <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              r_state     <= S_LOAD;
              r_load_req  <= 1'b1;
              r_stage_num <= 3'd0;
              r_buf_sel   <= 1'b0;
              r_busy      <= 1'b1;
            end
          end
          S_LOAD: begin
            if (load_done) begin
              r_state    <= S_RUN;
              r_load_req <= 1'b0;
              r_stage_en <= 1'b1;
            end
          end
          S_RUN: begin
            if (w_edge) begin
              r_stage_en <= 1'b0;
              if (w_last_stage) begin
                r_state     <= S_DRAIN;
                r_out_valid <= 1'b1;
              end else begin
                r_state     <= S_GAP;
                r_stage_num <= r_stage_num + 3'd1;
                r_buf_sel   <= ~r_buf_sel;
              end
            end
          end
          S_GAP: begin
            // One cycle with stage_en low lets the stage controller clear its counter.
            r_state    <= S_RUN;
            r_stage_en <= 1'b1;
          end
          S_DRAIN: begin
            // buf_sel keeps pointing at the result buffer after hand-off.
            if (out_ready) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_load_req  <= 1'b0;
            r_stage_en  <= 1'b0;
            r_stage_num <= 3'd0;
            r_buf_sel   <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign load_req  = r_load_req;
  assign stage_en  = r_stage_en;
  assign stage_num = r_stage_num;
  assign buf_sel   = r_buf_sel;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign done      = r_done;

endmodule
